// File: rtl/response_block_bridge_slave_pkg.sv
// Shared defaults and sizing helpers for the bridge response slave and its ID FIFO.
package response_block_bridge_slave_pkg;

    localparam int unsigned DEF_ADDR_WIDTH      = 32;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_ID_WIDTH        = 16;
    localparam int unsigned DEF_AUX_WIDTH       = 32;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;

    // Pointer width for a circular buffer of the given depth (at least one bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width; must be able to represent the value "depth" itself.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/response_block_bridge_slave_fifo.sv
// Outstanding-transaction FIFO: flop storage, explicit pointer wrap (any depth), head readable combinationally.
module resp_id_fifo_bridge
    import response_block_bridge_slave_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned   PW       = ptr_width(DEPTH);
    localparam int unsigned   CW       = count_width(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;

    // Next-state for storage, both pointers and the occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/response_block_bridge_slave.sv
// Bridge slave endpoint: gates requests onto an in-order memory port and returns one tagged response per grant.
module response_block_bridge_slave
    import response_block_bridge_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
    parameter int unsigned AUX_WIDTH       = DEF_AUX_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    input  logic [AUX_WIDTH-1:0]  data_aux_i,
    output logic                  data_gnt_o,
    output logic                  data_r_valid_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    output logic [AUX_WIDTH-1:0]  data_r_aux_o,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic                  mem_wen_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_r_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_r_rdata_i,
    output logic                  err_o
);

    localparam int unsigned ENTRY_W = ID_WIDTH + AUX_WIDTH + 1;
    localparam int unsigned CW      = count_width(MAX_OUTSTANDING);

    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;
    logic [ENTRY_W-1:0]    entry_in_s;
    logic [ENTRY_W-1:0]    head_s;
    logic [ID_WIDTH-1:0]   head_id_s;
    logic [AUX_WIDTH-1:0]  head_aux_s;
    logic                  head_wen_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  spurious_s;

    logic                  r_valid_q, r_valid_d;
    logic [ID_WIDTH-1:0]   r_id_q,    r_id_d;
    logic [AUX_WIDTH-1:0]  r_aux_q,   r_aux_d;
    logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
    logic                  err_q,     err_d;

    // Full is taken from the registered count only, so a same-cycle pop never opens the grant path.
    assign mem_req_o    = data_req_i & ~fifo_full_s;
    assign data_gnt_o   = mem_gnt_i & ~fifo_full_s;
    assign mem_add_o    = data_add_i;
    assign mem_wen_o    = data_wen_i;
    assign mem_wdata_o  = data_wdata_i;
    assign mem_be_o     = data_be_i;

    assign push_s       = data_req_i & data_gnt_o;
    assign pop_s        = mem_r_valid_i & ~fifo_empty_s;
    assign spurious_s   = mem_r_valid_i & (fifo_count_s == '0);
    assign entry_in_s   = {data_ID_i, data_aux_i, data_wen_i};
    assign {head_id_s, head_aux_s, head_wen_s} = head_s;

    resp_id_fifo_bridge #(
        .WIDTH (ENTRY_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (entry_in_s),
        .head_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Response register contents; ID/aux/rdata hold their last value between responses.
    always_comb begin
        r_valid_d = pop_s;
        r_id_d    = r_id_q;
        r_aux_d   = r_aux_q;
        r_rdata_d = r_rdata_q;
        if (pop_s) begin
            r_id_d    = head_id_s;
            r_aux_d   = head_aux_s;
            r_rdata_d = head_wen_s ? mem_r_rdata_i : '0;
        end else begin
            r_rdata_d = r_rdata_q;
        end
        err_d = err_q | spurious_s;
    end

    // Response and sticky error registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_aux_q   <= '0;
            r_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_aux_q   <= r_aux_d;
            r_rdata_q <= r_rdata_d;
            err_q     <= err_d;
        end
    end

    assign data_r_valid_o = r_valid_q;
    assign data_r_ID_o    = r_id_q;
    assign data_r_aux_o   = r_aux_q;
    assign data_r_rdata_o = r_rdata_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_response_block_bridge_slave.sv
// Directed plus randomized bench for response_block_bridge_slave against a queue-based transaction model.
module tb_response_block_bridge_slave;

    localparam int MO = 4;

    logic        clk;
    logic        rst_n;
    logic        data_req_i;
    logic [31:0] data_add_i;
    logic        data_wen_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [15:0] data_ID_i;
    logic [31:0] data_aux_i;
    logic        data_gnt_o;
    logic        data_r_valid_o;
    logic [15:0] data_r_ID_o;
    logic [31:0] data_r_aux_o;
    logic [31:0] data_r_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_add_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic        mem_r_valid_i;
    logic [31:0] mem_r_rdata_i;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] id;
        logic [31:0] aux;
        logic        wen;
    } txn_t;

    txn_t model_q[$];
    bit   model_err;

    response_block_bridge_slave #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .BE_WIDTH        (4),
        .ID_WIDTH        (16),
        .AUX_WIDTH       (32),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_ID_i      (data_ID_i),
        .data_aux_i     (data_aux_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_ID_o    (data_r_ID_o),
        .data_r_aux_o   (data_r_aux_o),
        .data_r_rdata_o (data_r_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_add_o      (mem_add_o),
        .mem_wen_o      (mem_wen_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_r_valid_i  (mem_r_valid_i),
        .mem_r_rdata_i  (mem_r_rdata_i),
        .err_o          (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check the pass-through path mid-cycle, then check registered outputs.
    task automatic step(input logic req, input logic wen, input logic [15:0] id, input logic [31:0] aux,
                        input logic gnt, input logic rv, input logic [31:0] rdata);
        logic        full_e;
        logic        gnt_e;
        logic        valid_e;
        txn_t        head;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        addr = $urandom;
        wd   = $urandom;
        be   = 4'($urandom);
        data_req_i    = req;
        data_wen_i    = wen;
        data_ID_i     = id;
        data_aux_i    = aux;
        data_add_i    = addr;
        data_wdata_i  = wd;
        data_be_i     = be;
        mem_gnt_i     = gnt;
        mem_r_valid_i = rv;
        mem_r_rdata_i = rdata;
        #3;
        full_e = (model_q.size() == MO);
        gnt_e  = gnt & ~full_e;
        chk("mem_req", 64'(mem_req_o), 64'(req & ~full_e));
        chk("data_gnt", 64'(data_gnt_o), 64'(gnt_e));
        chk("pass_through", {mem_add_o, mem_wen_o, mem_be_o, mem_wdata_o[26:0]},
                            {addr, wen, be, wd[26:0]});
        valid_e = 1'b0;
        head    = '{id: 16'h0, aux: 32'h0, wen: 1'b0};
        if (rv) begin
            if (model_q.size() != 0) begin
                head    = model_q.pop_front();
                valid_e = 1'b1;
            end else begin
                model_err = 1'b1;
            end
        end
        if (req && gnt_e) begin
            model_q.push_back('{id: id, aux: aux, wen: wen});
        end
        @(posedge clk);
        #1;
        chk("r_valid", 64'(data_r_valid_o), 64'(valid_e));
        if (valid_e) begin
            chk("r_id", 64'(data_r_ID_o), 64'(head.id));
            chk("r_aux", 64'(data_r_aux_o), 64'(head.aux));
            chk("r_rdata", 64'(data_r_rdata_o), head.wen ? 64'(rdata) : 64'h0);
        end
        chk("err", 64'(err_o), 64'(model_err));
        chk("count", 64'(dut.u_fifo.count_o), 64'(model_q.size()));
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        data_req_i    = 1'b0;
        data_wen_i    = 1'b0;
        data_ID_i     = 16'h0;
        data_aux_i    = 32'h0;
        data_add_i    = 32'h0;
        data_wdata_i  = 32'h0;
        data_be_i     = 4'h0;
        mem_gnt_i     = 1'b0;
        mem_r_valid_i = 1'b0;
        mem_r_rdata_i = 32'h0;
        @(posedge clk);
        #1;
        model_q.delete();
        model_err = 1'b0;
        chk("rst_r_valid", 64'(data_r_valid_o), 64'h0);
        chk("rst_r_id", 64'(data_r_ID_o), 64'h0);
        chk("rst_r_aux", 64'(data_r_aux_o), 64'h0);
        chk("rst_r_rdata", 64'(data_r_rdata_o), 64'h0);
        chk("rst_err", 64'(err_o), 64'h0);
        chk("rst_count", 64'(dut.u_fifo.count_o), 64'h0);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    function automatic logic [15:0] rand_id();
        logic [15:0] one;
        one = 16'h1;
        return one << $urandom_range(0, 15);
    endfunction

    initial begin
        model_err = 1'b0;
        do_reset();

        // single read, response two cycles after the grant
        step(1'b1, 1'b1, 16'h0004, 32'h0000_00A5, 1'b1, 1'b0, 32'h0);
        idle();
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        idle();

        // write returns zero read data
        step(1'b1, 1'b0, 16'h0001, 32'h0000_1234, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);

        // fill to four, blocked fifth, pop without same-cycle grant, then grant, then in-order drain
        step(1'b1, 1'b1, 16'h0001, 32'h11, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 16'h0002, 32'h22, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 16'h0004, 32'h44, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 16'h0008, 32'h88, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 16'h0010, 32'hF0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 16'h0010, 32'hF0, 1'b1, 1'b1, 32'h1111_0001);
        step(1'b1, 1'b1, 16'h0010, 32'hF0, 1'b1, 1'b1, 32'h2222_0002);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'h4444_0004);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'h8888_0008);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'h1010_0010);

        // steady push+pop at two outstanding
        step(1'b1, 1'b1, rand_id(), $urandom, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, rand_id(), $urandom, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom), rand_id(), $urandom, 1'b1, 1'b1, $urandom);
        end
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, $urandom);
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, $urandom);

        // spurious response on empty FIFO sets the sticky error
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'h5A5A_5A5A);
        idle();
        idle();

        // reset with three outstanding, then a late memory response is treated as spurious
        step(1'b1, 1'b1, 16'h0100, 32'h1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 16'h0200, 32'h2, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 16'h0400, 32'h3, 1'b1, 1'b0, 32'h0);
        do_reset();
        idle();
        idle();
        step(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1, 32'h7777_7777);
        idle();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rv;
            if (model_q.size() != 0) rv = ($urandom_range(0, 1) == 1);
            else                     rv = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 7, 1'($urandom), rand_id(), $urandom,
                 $urandom_range(0, 3) != 0, rv, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
